// File: rtl/fetch_unit.sv
// Instruction fetch stage: keeps the PC, issues one imem request at a time and
// hands the returned word to decode through a valid/ready handshake.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h00000000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            instr_ready,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      opcode
);

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD,
        DROP
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_nxt;
    logic [XLEN-1:0] addr_nxt;
    logic [XLEN-1:0] instr_pc_nxt;
    logic [31:0]     instr_nxt;
    logic            req_nxt;
    logic            valid_nxt;
    logic [XLEN-1:0] target;
    logic            unused_redirect_lsbs;

    // Fetches are word aligned, so the low redirect bits carry no information.
    assign target               = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign opcode = instr[6:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC;
            instr_valid <= 1'b0;
            instr       <= NOP;
            instr_pc    <= RESET_PC;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            imem_req    <= req_nxt;
            imem_addr   <= addr_nxt;
            instr_valid <= valid_nxt;
            instr       <= instr_nxt;
            instr_pc    <= instr_pc_nxt;
        end
    end

    // imem_addr only moves together with a new request, so it stays stable
    // for the whole lifetime of the outstanding fetch.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        req_nxt      = 1'b0;
        addr_nxt     = imem_addr;
        valid_nxt    = instr_valid;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;

        case (state)
            IDLE: begin
                req_nxt   = 1'b1;
                state_nxt = WAIT;
                if (redirect_valid) begin
                    pc_nxt   = target;
                    addr_nxt = target;
                end else begin
                    addr_nxt = pc;
                end
            end

            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt = target;
                    if (imem_rvalid) begin
                        req_nxt  = 1'b1;
                        addr_nxt = target;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (imem_rvalid) begin
                    instr_nxt    = imem_rdata;
                    instr_pc_nxt = imem_addr;
                    valid_nxt    = 1'b1;
                    pc_nxt       = imem_addr + XLEN'(4);
                    state_nxt    = HOLD;
                end
            end

            HOLD: begin
                if (redirect_valid) begin
                    valid_nxt = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = target;
                    pc_nxt    = target;
                    state_nxt = WAIT;
                end else if (instr_valid && instr_ready) begin
                    valid_nxt = 1'b0;
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                    state_nxt = WAIT;
                end
            end

            DROP: begin
                valid_nxt = 1'b0;
                if (redirect_valid) begin
                    pc_nxt = target;
                end
                // The stale response only frees the memory port; its data is dropped.
                if (imem_rvalid) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = redirect_valid ? target : pc;
                    state_nxt = WAIT;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core, directly upstream of the immediate sign-extender.
- Holds the PC and issues word fetches to instruction memory, with one request outstanding at a time.
- Buffers the returned instruction and presents it, with its PC and 7-bit opcode, to decode/signext through a valid/ready handshake.
- Accepts PC redirects from branch/jump resolution and discards any stale in-flight response.

Parameters:
- RESET_PC, 32'h00000000, PC value loaded on reset.
- XLEN, 32, data/address width; only 32 is supported.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  one-cycle fetch request pulse.
- imem_addr  output  XLEN  fetch address; held stable from the request until its response.
- imem_rvalid  input  1  response valid; earliest is the cycle after imem_req.
- imem_rdata  input  32  instruction word, valid with imem_rvalid.
- redirect_valid  input  1  load new PC (branch/jump taken).
- redirect_pc  input  XLEN  redirect target; bits [1:0] are ignored (forced to 0).
- instr_ready  input  1  downstream accepts the instruction.
- instr_valid  output  1  instr/instr_pc/opcode are valid.
- instr  output  32  fetched instruction word (the signext instruct input).
- instr_pc  output  XLEN  address of instr.
- opcode  output  7  instr[6:0] (the signext typ input); combinational from the instr register.

Behaviour:
- Reset (async assert, sync release):
  - pc=RESET_PC, imem_addr=RESET_PC, imem_req=0.
  - instr_valid=0, instr=32'h00000013 (NOP), instr_pc=RESET_PC.
  - state=IDLE.
- All outputs except opcode are registered. Exactly one memory request is outstanding at most.
- States: IDLE, WAIT, HOLD, DROP.
- IDLE:
  - Next edge: imem_req<=1, imem_addr<=pc, go WAIT.
  - If redirect_valid: request is issued to redirect_pc instead; pc<=redirect_pc.
- WAIT:
  - imem_req drops to 0 after one cycle.
  - On imem_rvalid with no redirect: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, pc<=imem_addr+4, go HOLD.
- HOLD:
  - instr_valid stays 1 and instr/instr_pc are stable until instr_valid&&instr_ready.
  - On handshake: instr_valid<=0, imem_req<=1, imem_addr<=pc, go WAIT.
  - Minimum throughput with 1-cycle memory latency: one instruction per 3 cycles (req, rvalid, handshake).
- Redirect priority: redirect_valid overrides normal progress in every state; pc<=redirect_pc&~3.
  - WAIT, no rvalid this cycle: go DROP.
  - WAIT with rvalid the same cycle: discard the data, issue a request to the redirect target next edge, stay WAIT.
  - HOLD: a same-cycle handshake still counts as consumed. instr_valid<=0 regardless; issue a request to the redirect target; go WAIT.
  - DROP: further redirects update pc only.
- DROP:
  - Wait for the stale imem_rvalid, discard it, then issue a request to the current pc and go WAIT.
  - instr_valid=0 throughout.
- imem_rvalid received in IDLE or HOLD is ignored (protocol error, no state change).
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC+4 = 32'h00000000.
- Reset asserted mid-operation:
  - Immediate return to reset values; the in-flight response is lost.
  - An imem_rvalid arriving in the first IDLE cycle after release is ignored.
- opcode has no separate register; it changes only when instr is loaded.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, instr_ready=1 → imem_req at cycle 1 with addr 0; instr_valid with instr_pc 0, 4, 8 every 3 cycles; opcode=instr[6:0].
- Memory returns 32'h00500093 (addi), then 32'h00002083 (lw) → opcode 7'b0010011, then 7'b0000011; instr matches rdata exactly.
- instr_ready=0 for 5 cycles while instr_valid → instr, instr_pc and opcode stable, no imem_req; after ready=1, the next request goes to instr_pc+4.
- Redirect to 32'h00000102 in WAIT, response 3 cycles later → stale data dropped and never valid; the next request goes to 32'h00000100; instr_pc=0x100.
- Redirect coincident with imem_rvalid → that word is discarded; request to the target the next cycle; no instr_valid for the old word.
- RESET_PC=32'hFFFFFFFC → second fetch address is 32'h00000000. Assert rst_n low during WAIT → all outputs return to reset values asynchronously, and fetching restarts at RESET_PC.
